// File: rtl/oversampled_pattern_tx.sv
// Oversampled pattern transmitter: expands each symbol bit of a captured
// pattern into OSF identical samples and emits them as 32-bit words, MSB
// first, one word per P strobe, with GAP idle cycles between strobes.
module oversampled_pattern_tx #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Start,
  input  logic [SAMPLES-1:0] DataIn,
  output logic               Busy,
  output logic [31:0]        DataOut,
  output logic               P,
  output logic               Done
);

  localparam int B   = 32 / OSF;
  localparam int W   = SAMPLES * OSF / 32;
  localparam int WCW = (W > 1) ? $clog2(W) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(W - 1);
  localparam logic [7:0]     GAP_LOAD  = 8'(GAP);

  if (((SAMPLES * OSF) % 32) != 0 || OSF < 1 || OSF > 32 ||
      (OSF & (OSF - 1)) != 0 || GAP < 0 || GAP > 255) begin : g_bad_params
    $error("oversampled_pattern_tx: illegal SAMPLES/OSF/GAP combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [SAMPLES-1:0] shreg_q, shreg_d;
  logic [WCW-1:0]     wcnt_q,  wcnt_d;
  logic [7:0]         gcnt_q,  gcnt_d;
  logic               busy_q,  busy_d;
  logic               p_q,     p_d;
  logic               done_q,  done_d;
  logic [31:0]        dout_q,  dout_d;

  // Top B symbol bits of the shift register, each replicated OSF times.
  logic [B-1:0] top_bits;
  logic [31:0]  expanded;

  assign top_bits = shreg_q[SAMPLES-1 -: B];

  for (genvar j = 0; j < B; j++) begin : g_expand
    assign expanded[31-j*OSF -: OSF] = {OSF{top_bits[B-1-j]}};
  end

  // Next-state logic: capture, emit/shift, gap countdown; Enable=0 freezes all.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    p_d     = 1'b0;
    done_d  = 1'b0;
    if (Enable) begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            shreg_d = DataIn;
            wcnt_d  = '0;
            busy_d  = 1'b1;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          dout_d  = expanded;
          p_d     = 1'b1;
          shreg_d = shreg_q << B;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (GAP != 0) begin
            gcnt_d  = GAP_LOAD;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          gcnt_d = gcnt_q - 1'b1;
          if (gcnt_q == 8'd1) state_d = S_EMIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; Reset=0 abandons any frame and clears all.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
      p_q     <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= busy_d;
      p_q     <= p_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign Busy    = busy_q;
  assign DataOut = dout_q;
  assign P       = p_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_oversampled_pattern_tx.sv
// Scoreboard bench for oversampled_pattern_tx: default-parameter instance plus
// a SAMPLES=4/OSF=32/GAP=0 instance. Expected words come from a sample-level
// reference model and are checked by independent monitors.
`timescale 1ns/1ps
module tb_oversampled_pattern_tx;

  localparam int S1 = 128, OSF1 = 8,  GAP1 = 1, W1 = S1 * OSF1 / 32;
  localparam int S2 = 4,   OSF2 = 32, GAP2 = 0, W2 = S2 * OSF2 / 32;

  typedef struct packed {
    logic [31:0] word;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset = 1'b0, Enable = 1'b1, Start = 1'b0;
  logic [S1-1:0] DataIn = '0;
  logic          Busy, P, Done;
  logic [31:0]   DataOut;

  logic          Enable2 = 1'b1, Start2 = 1'b0;
  logic [S2-1:0] DataIn2 = '0;
  logic          Busy2, P2, Done2;
  logic [31:0]   DataOut2;

  oversampled_pattern_tx #(.SAMPLES(S1), .OSF(OSF1), .GAP(GAP1)) dut (
    .clk(clk), .Reset(Reset), .Enable(Enable), .Start(Start), .DataIn(DataIn),
    .Busy(Busy), .DataOut(DataOut), .P(P), .Done(Done)
  );

  oversampled_pattern_tx #(.SAMPLES(S2), .OSF(OSF2), .GAP(GAP2)) dut2 (
    .clk(clk), .Reset(Reset), .Enable(Enable2), .Start(Start2), .DataIn(DataIn2),
    .Busy(Busy2), .DataOut(DataOut2), .P(P2), .Done(Done2)
  );

  int   n_tests = 0, n_fail = 0;
  exp_t q1[$], q2[$];
  int   frame_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample s of the frame is symbol bit (samples-1 - s/osf); word w holds
  // samples w*32 .. w*32+31 with the earliest sample in bit 31.
  function automatic logic [31:0] ref_word(input logic [127:0] din, input int samples,
                                           input int osf, input int w);
    logic [31:0] r;
    int s;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      s = w * 32 + b;
      r[31-b] = din[samples - 1 - s / osf];
    end
    return r;
  endfunction

  task automatic push_frame1(input logic [S1-1:0] din);
    exp_t e;
    for (int w = 0; w < W1; w++) begin
      e.word = ref_word(din, S1, OSF1, w);
      e.done = (w == W1 - 1);
      q1.push_back(e);
    end
  endtask

  task automatic push_frame2(input logic [S2-1:0] din);
    exp_t e;
    for (int w = 0; w < W2; w++) begin
      e.word = ref_word({124'b0, din}, S2, OSF2, w);
      e.done = (w == W2 - 1);
      q2.push_back(e);
    end
  endtask

  // Monitor for the default instance: words, Done, strobe spacing, Busy, hold.
  logic        busy_m = 1'b0;
  int          since = 0;
  bit          first = 1'b0;
  logic [31:0] last_word = '0;

  always @(posedge clk) begin
    logic en_s, rst_s, st_s;
    exp_t e;
    int   sp;
    en_s  = Enable;
    rst_s = Reset;
    st_s  = Start;
    #1;
    if (!rst_s) begin
      chk("rst_busy", Busy, 0);
      chk("rst_p", P, 0);
      chk("rst_done", Done, 0);
      chk("rst_dataout", DataOut, 32'h0);
      q1.delete();
      busy_m    = 1'b0;
      last_word = '0;
      frame_cnt = 0;
    end else begin
      sp = first ? 1 : GAP1 + 1;
      if (busy_m && en_s) since++;
      if (!en_s) begin
        chk("frozen_p", P, 0);
        chk("frozen_done", Done, 0);
      end
      if (P) begin
        if (q1.size() == 0) begin
          chk("unexpected_p", P, 0);
        end else begin
          e = q1.pop_front();
          chk("word", DataOut, e.word);
          chk("done_flag", Done, e.done);
          chk("spacing", since, sp);
          last_word = e.word;
          since     = 0;
          first     = 1'b0;
          frame_cnt++;
          if (e.done) busy_m = 1'b0;
        end
      end else begin
        chk("done_without_p", Done, 0);
        if (busy_m && en_s && since == sp) chk("missing_strobe", P, 1);
        if (!busy_m && en_s && st_s) begin
          busy_m    = 1'b1;
          since     = 0;
          first     = 1'b1;
          frame_cnt = 0;
        end
      end
      chk("busy", Busy, busy_m);
      chk("hold_dataout", DataOut, last_word);
    end
  end

  // Monitor for the GAP=0 instance: words must come on consecutive cycles.
  bit exp_p2 = 1'b0;

  always @(posedge clk) begin
    logic rst2_s;
    exp_t e2;
    rst2_s = Reset;
    #1;
    if (!rst2_s) begin
      chk("d2_rst_p", P2, 0);
      chk("d2_rst_busy", Busy2, 0);
      q2.delete();
      exp_p2 = 1'b0;
    end else begin
      if (exp_p2 && !P2) chk("d2_consecutive", P2, 1);
      if (P2) begin
        if (q2.size() == 0) begin
          chk("d2_unexpected_p", P2, 0);
        end else begin
          e2 = q2.pop_front();
          chk("d2_word", DataOut2, e2.word);
          chk("d2_done_flag", Done2, e2.done);
        end
      end else begin
        chk("d2_done_without_p", Done2, 0);
      end
      exp_p2 = (q2.size() > 0);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (Busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("idle_timeout", Busy, 0);
  endtask

  // mode 0: plain; 1: random Enable and stray Starts; 2: 5-cycle freeze after
  // 10th strobe with stray Starts; 3: reset after 15th strobe.
  task automatic run_frame(input logic [S1-1:0] din, input int mode);
    int t;
    bit froze;
    froze = 1'b0;
    @(negedge clk);
    wait_idle();
    DataIn = din;
    Enable = 1'b1;
    Start  = 1'b1;
    push_frame1(din);
    @(negedge clk);
    Start  = 1'b0;
    DataIn = {$urandom, $urandom, $urandom, $urandom};
    t = 0;
    while (Busy === 1'b1 && t < 3000) begin
      if (mode == 1) begin
        Enable = ($urandom_range(3) != 0);
        Start  = 1'($urandom_range(1));
      end
      if (mode == 2) begin
        Start = 1'($urandom_range(1));
        if (frame_cnt == 10 && !froze) begin
          froze  = 1'b1;
          Enable = 1'b0;
          repeat (5) @(negedge clk);
          Enable = 1'b1;
        end
      end
      if (mode == 3 && frame_cnt == 15) begin
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        break;
      end
      @(negedge clk);
      t++;
    end
    Start  = 1'b0;
    Enable = 1'b1;
    if (t >= 3000) chk("frame_timeout", Busy, 0);
  endtask

  task automatic run_frame2(input logic [S2-1:0] din);
    @(negedge clk);
    DataIn2 = din;
    Start2  = 1'b1;
    push_frame2(din);
    @(negedge clk);
    Start2  = 1'b0;
    DataIn2 = 4'($urandom);
    repeat (W2 + 3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b1;

    run_frame({4'hA, 124'h0}, 0);
    run_frame(128'h1, 0);
    run_frame({128{1'b1}}, 0);
    run_frame({4'hA, 124'h0}, 2);
    run_frame({$urandom, $urandom, $urandom, $urandom}, 3);
    run_frame({$urandom, $urandom, $urandom, $urandom}, 0);
    for (int k = 0; k < 6; k++)
      run_frame({$urandom, $urandom, $urandom, $urandom}, 1);

    run_frame2(4'b1011);
    run_frame2(4'($urandom));
    run_frame2(4'b0110);

    @(negedge clk);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oversampled_pattern_tx.md
# oversampled_pattern_tx

Transmit-side counterpart of the correlation engine. The block accepts one SAMPLES-bit symbol pattern and expands every bit to OSF identical samples. It packs the samples into 32-bit words and presents them one word per P strobe, MSB first. This is exactly the word stream the correlator consumes by shift-in on its DataIn1/P inputs. The block sits between the pattern source (register or ROM) and the correlator input, and replaces the file-driven feed in closed-loop simulation and on hardware.

## Interface
- SAMPLES, 128, symbol bits per frame
- OSF, 8, oversampling factor; power of two, 1..32
- GAP, 1, idle cycles (P=0) inserted after each strobed word; 0..255
- clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset (Reset=0 at a rising edge resets)
- Enable  in  1  1 = run; 0 = freeze all state, counters and outputs hold, P forced 0
- Start  in  1  request to send DataIn; sampled only in IDLE
- DataIn  in  SAMPLES  symbol pattern; bit SAMPLES-1 sent first
- Busy  out  1  frame in progress
- DataOut  out  32  current oversampled word
- P  out  1  one-cycle strobe, DataOut valid
- Done  out  1  one-cycle pulse coincident with last word's P

## Operation
- Derived values:
  - B = 32/OSF input bits per word.
  - W = SAMPLES*OSF/32 words per frame (defaults: B=4, W=32).
  - SAMPLES*OSF must be a multiple of 32; otherwise elaboration error.
- Expansion: word i uses DataIn bits [SAMPLES-1-i*B -: B]. Input bit j of that slice (j=0 is MSB) fills DataOut[31-j*OSF -: OSF] with copies of itself.
- FSM states:
  - IDLE: Busy=0. Transition on Enable & Start: capture DataIn into shift register, clear word counter, go to EMIT.
  - EMIT: drive DataOut = expansion of top B bits of shift register. Assert P=1, shift register left by B, increment word counter.
    - If this is word W-1: also assert Done=1, go to IDLE.
    - Else if GAP=0: stay in EMIT.
    - Else: load gap counter with GAP, go to WAIT.
  - WAIT: P=0. Decrement gap counter; at 1, go to EMIT.
- DataOut holds the last strobed word until the next strobe. It is not cleared on frame end.
- Start while Busy=1 is ignored; no queuing.
- DataIn changes after capture have no effect on the frame in flight.
- Enable=0 in any state: no transition, no counter change, P=0, Done=0. Resume continues exactly where frozen. A strobe suppressed by Enable=0 is reissued when Enable returns to 1; no word is lost.
- Reset=0 overrides everything, including mid-frame:
  - State goes to IDLE.
  - Busy=0, P=0, Done=0, DataOut=0, counters=0.
  - Frame is abandoned.

## Timing
- Reset values: Busy=0, DataOut=32'h0, P=0, Done=0.
- Start sampled high at edge N (IDLE, Enable=1): Busy=1 from N. First P/DataOut at edge N+1.
- Word i strobes at edge N+1+i*(GAP+1), assuming Enable held 1.
- Done=1 together with P at edge N+1+(W-1)*(GAP+1). Busy=0 from that same edge; a new Start is accepted at the next edge.
- Frame length, Start to last strobe: 1+(W-1)*(GAP+1) cycles. Defaults: 63 cycles, P every 2nd cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset=0 held 3 cycles, then released -> Busy, P and Done at 0; DataOut=32'h0.
- Defaults, DataIn={4'hA,124'h0}, Start pulse -> exactly 32 P pulses, 2 cycles apart. Word0=32'hFF00FF00, words 1..31=32'h0. Done on the 32nd P.
- DataIn=128'h1 -> words 0..30=0, word31=32'h000000FF with Done=1. Then DataIn=all ones -> 32 words of 32'hFFFFFFFF.
- GAP=0, OSF=32, SAMPLES=4, DataIn=4'b1011 -> 4 consecutive P cycles. Words: FFFFFFFF, 00000000, FFFFFFFF, FFFFFFFF.
- Enable=0 for 5 cycles after the 10th strobe -> no P during the freeze. Strobes resume with word 10; total still 32; word values unchanged. Start pulses during Busy are ignored.
- Reset=0 at the 15th strobe, then new Start -> outputs zero and Busy=0 immediately. The new frame restarts at word 0 with the new DataIn.
